sprite_blitter: RTL



---
 rtl/sprite_pkg.sv | 19 +
 rtl/blit_xy_counter.sv | 41 ++++
 rtl/sprite_blitter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite and frame-buffer geometry, key color and blitter state encoding.
// The sprite ROM modules import the same constants so geometry stays consistent.
package sprite_pkg;

  localparam int SPR_W = 20;
  localparam int SPR_H = 22;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;

  localparam logic [11:0] TRANSPARENT = 12'h808;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/blit_xy_counter.sv
// Column/row walker over one sprite: x runs across a row, then y steps down.
// Provides a flag that is high while the counters sit on the final pixel.
module blit_xy_counter #(
  parameter  int SPR_W = sprite_pkg::SPR_W,
  parameter  int SPR_H = sprite_pkg::SPR_H,
  localparam int X_W   = $clog2(SPR_W),
  localparam int Y_W   = $clog2(SPR_H)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           clr,
  input  logic           inc,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic row_end;
  logic col_end;

  assign row_end = (x == X_W'(SPR_W - 1));
  assign col_end = (y == Y_W'(SPR_H - 1));
  assign last    = row_end && col_end;

  // NOTE: clocked state is written only with non-blocking assignments so every
  // reader of x and y sees the pre-edge value, independent of block order.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (row_end) begin
        x <= '0;
        y <= col_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one palette sprite from a combinational ROM into the frame buffer,
// skipping the key color, optionally mirrored, clipped at the screen edge.
module sprite_blitter #(
  parameter int          SPR_W       = sprite_pkg::SPR_W,
  parameter int          SPR_H       = sprite_pkg::SPR_H,
  parameter int          FB_W        = sprite_pkg::FB_W,
  parameter int          FB_H        = sprite_pkg::FB_H,
  parameter logic [11:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  pos_x,
  input  logic [8:0]  pos_y,
  input  logic        mirror,
  output logic        busy,
  output logic        done,
  output logic [8:0]  rom_addr,
  input  logic [11:0] rom_color,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [11:0] fb_data,
  input  logic        fb_ready
);

  import sprite_pkg::*;

  localparam int X_W = $clog2(SPR_W);
  localparam int Y_W = $clog2(SPR_H);

  state_t         state;
  logic [9:0]     pos_x_q;
  logic [8:0]     pos_y_q;
  logic           mirror_q;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           last;
  logic           cnt_clr;
  logic           cnt_inc;

  logic [X_W-1:0] col;
  logic [10:0]    x_sum;
  logic [9:0]     y_sum;
  logic           on_screen;
  logic           pix_needed;
  logic [16:0]    pix_addr;
  logic           stall;

  blit_xy_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  // Sums are one bit wider than the position so a sprite hanging past the
  // right or bottom edge compares as off-screen instead of wrapping.
  always_comb begin
    col        = mirror_q ? X_W'(SPR_W - 1) - x : x;
    rom_addr   = 9'(y) * 9'(SPR_W) + 9'(col);
    x_sum      = 11'(pos_x_q) + 11'(x);
    y_sum      = 10'(pos_y_q) + 10'(y);
    on_screen  = (x_sum < 11'(FB_W)) && (y_sum < 10'(FB_H));
    pix_needed = (rom_color != TRANSPARENT) && on_screen;
    pix_addr   = 17'(y_sum) * 17'(FB_W) + 17'(x_sum);
    stall      = fb_we && !fb_ready;
    cnt_clr    = (state == IDLE) && start;
    cnt_inc    = (state == WRITE) && !stall;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      mirror_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pos_x_q  <= pos_x;
            pos_y_q  <= pos_y;
            mirror_q <= mirror;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          fb_data <= rom_color;
          if (pix_needed) fb_addr <= pix_addr;
          fb_we   <= pix_needed;
          state   <= WRITE;
        end
        WRITE: begin
          // A skipped pixel never waits; a needed one holds address and data until accepted.
          if (!stall) begin
            fb_we <= 1'b0;
            state <= last ? DONE : READ;
          end
        end
        DONE: begin
          // First DONE cycle raises done; second drops it and returns to IDLE.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
